lin_schedule_sequencer: RTL and testbench
=========================================

// Module: lin_schedule_sequencer
// PURPOSE
//  Writable, multi-table LIN schedule memory with a built-in slot sequencer.
//  Firmware loads DEPTH entries and NUM_TABLES [first,last] ranges, then selects a table and sets run.
//  The block walks the selected table and hands one frame header per slot to the LIN master FSM, paced by a bit-time tick.
//  It replaces the fixed combinational schedule table ROM and sits between the APB register file and the LIN master.
// PARAMETERS
//  DATA_W     32  entry width; must be >= 16
//  DEPTH      32  number of schedule entries
//  ADDR_W      5  entry index width; must satisfy 2**ADDR_W >= DEPTH
//  NUM_TABLES  4  number of selectable schedule tables
//  TSEL_W      2  table select width; must satisfy 2**TSEL_W >= NUM_TABLES
// PORTS
//  clk        in   1       system clock
//  reset_n    in   1       asynchronous active-low reset
//  wr_en      in   1       entry write strobe
//  wr_addr    in   ADDR_W  entry write index
//  wr_data    in   DATA_W  entry write data
//  rd_addr    in   ADDR_W  readback index
//  rd_data    out  DATA_W  readback data, registered, 1-cycle latency
//  cfg_wr     in   1       table range write strobe
//  cfg_tbl    in   TSEL_W  table being configured
//  cfg_first  in   ADDR_W  first entry of the table
//  cfg_last   in   ADDR_W  last entry of the table
//  run        in   1       level: 1 = run schedule, 0 = stop at the next slot boundary
//  tbl_sel    in   TSEL_W  requested table
//  tick       in   1       one-cycle bit-time pulse
//  frm_valid  out  1       frame request valid
//  frm_ready  in   1       LIN master accepts the request
//  frm_pid    out  6       entry[5:0], frame identifier
//  frm_type   out  2       entry[7:6]: 0 = uncond, 1 = event, 2 = sporadic, 3 = diagnostic
//  frm_entry  out  DATA_W  full entry word; upper bits are payload hints
//  frm_idx    out  ADDR_W  index of the entry being issued
//  busy       out  1       state != IDLE
//  cur_tbl    out  TSEL_W  table currently executing
//  err_cfg    out  1       one-cycle pulse on an illegal table start or switch
// BEHAVIOUR
//  Entry format: [5:0] PID, [7:6] type, [15:8] slot length in ticks (0 is treated as 1), [DATA_W-1:16] hints.
//  Reset values:
//   - All entries and table ranges = 0.
//   - All outputs = 0; state = IDLE.
//   - Reset mid-slot aborts immediately with no handshake completion.
//  Writes:
//   - wr_en takes effect at the clock edge.
//   - A FETCH of the same index in that cycle returns the OLD data.
//   - wr_addr >= DEPTH is ignored.
//   - cfg_wr for cfg_tbl >= NUM_TABLES is ignored.
//  Legal table: first <= last < DEPTH and table index < NUM_TABLES.
//  FSM (state names shown in capitals):
//   - IDLE: when run=1, if tbl_sel is legal, latch cur_tbl <= tbl_sel, idx <= first, go to FETCH.
//     Otherwise pulse err_cfg and stay in IDLE.
//   - FETCH: register entry[idx], go to ISSUE. frm_valid rises 2 cycles after run is first sampled high.
//   - ISSUE: frm_valid=1 and all frm_* are stable until frm_ready=1.
//     A request is never withdrawn, even if run drops.
//     On the handshake (valid & ready), load slot_cnt <= max(len,1) and go to SLOT. frm_valid drops the next cycle.
//   - SLOT: each tick decrements slot_cnt. When a tick brings slot_cnt to 0, the slot boundary is reached:
//     - run=0: go to IDLE.
//     - tbl_sel != cur_tbl and tbl_sel is legal: switch cur_tbl, idx <= new first, go to FETCH.
//     - tbl_sel != cur_tbl and tbl_sel is illegal: pulse err_cfg, keep cur_tbl, advance normally.
//     - otherwise: idx <= (idx==last) ? first : idx+1 (wrap), go to FETCH.
//  Ticks arriving during FETCH or ISSUE are not counted.
//  Range reconfiguration of the running table takes effect at the next wrap or fetch.
//  A length-1 table repeats the same entry every slot.
// TESTING
//  - Load entries 0..2 with PIDs 0x23, 0x20, 0x30 and len 2; table0 = [0,2]; run=1, frm_ready=1, tick every 4 clk
//    -> PID order 23,20,30,23 (wrap), one request per 2 ticks.
//  - frm_ready held 0 for 10 cycles in ISSUE -> frm_valid and frm_pid stay constant; slot_cnt is not loaded until ready.
//  - Running table0 = [0,2], tbl_sel set to 1 with table1 = [28,31] mid-slot at idx 1
//    -> the next issued index is 28, cur_tbl=1, and no entry 2 is issued.
//  - Table2 = [5,3]; run=1 with tbl_sel=2 -> err_cfg single pulse, busy stays 0, no frm_valid.
//  - wr_en to the idx being fetched in the same cycle -> old word issued; the new word is issued on the next visit.
//  - reset_n low during SLOT -> all outputs 0 asynchronously; after release, IDLE; entries read back as 0.

Source files
------------

// File: rtl/lin_schedule_sequencer.sv
// Writable multi-table LIN schedule memory with slot sequencer.
// Ports: entry write/readback, table range config, run/tbl_sel control,
//   tick pacing, frm_* valid/ready request to the LIN master, status.
module lin_schedule_sequencer #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_W     = 5,
    parameter int NUM_TABLES = 4,
    parameter int TSEL_W     = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              cfg_wr,
    input  logic [TSEL_W-1:0] cfg_tbl,
    input  logic [ADDR_W-1:0] cfg_first,
    input  logic [ADDR_W-1:0] cfg_last,
    input  logic              run,
    input  logic [TSEL_W-1:0] tbl_sel,
    input  logic              tick,
    output logic              frm_valid,
    input  logic              frm_ready,
    output logic [5:0]        frm_pid,
    output logic [1:0]        frm_type,
    output logic [DATA_W-1:0] frm_entry,
    output logic [ADDR_W-1:0] frm_idx,
    output logic              busy,
    output logic [TSEL_W-1:0] cur_tbl,
    output logic              err_cfg
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        SLOT
    } state_t;

    localparam int NT_ALL = 2 ** TSEL_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [TSEL_W:0] NT_C    = (TSEL_W + 1)'(NUM_TABLES);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] tfirst [NT_ALL];
    logic [ADDR_W-1:0] tlast  [NT_ALL];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [TSEL_W-1:0] tbl_q, tbl_d;
    logic [7:0]        slot_q, slot_d;
    logic              err_q, err_d;
    logic              ehold_q, ehold_d;
    logic [DATA_W-1:0] ent_q;
    logic [DATA_W-1:0] rd_q;
    logic [7:0]        len;

    function automatic logic legal(input logic [TSEL_W-1:0] t);
        return ({1'b0, t} < NT_C) &&
               (tfirst[t] <= tlast[t]) &&
               ({1'b0, tlast[t]} < DEPTH_C);
    endfunction

    assign len = ent_q[15:8];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tbl_d   = tbl_q;
        slot_d  = slot_q;
        err_d   = 1'b0;
        ehold_d = ehold_q;
        unique case (state_q)
            IDLE: begin
                // ehold keeps a held-high run on a bad table
                // from pulsing err_cfg every cycle
                if (!run) begin
                    ehold_d = 1'b0;
                end else if (legal(tbl_sel)) begin
                    tbl_d   = tbl_sel;
                    idx_d   = tfirst[tbl_sel];
                    state_d = FETCH;
                    ehold_d = 1'b0;
                end else if (!ehold_q) begin
                    err_d   = 1'b1;
                    ehold_d = 1'b1;
                end
            end
            FETCH: begin
                state_d = ISSUE;
            end
            ISSUE: begin
                if (frm_ready) begin
                    slot_d  = (len == 8'd0) ? 8'd1 : len;
                    state_d = SLOT;
                end
            end
            SLOT: begin
                if (tick) begin
                    if (slot_q > 8'd1) begin
                        slot_d = slot_q - 8'd1;
                    end else begin
                        slot_d  = 8'd0;
                        state_d = FETCH;
                        if (!run) begin
                            state_d = IDLE;
                        end else if (tbl_sel != tbl_q &&
                                     legal(tbl_sel)) begin
                            tbl_d = tbl_sel;
                            idx_d = tfirst[tbl_sel];
                        end else begin
                            err_d = (tbl_sel != tbl_q);
                            // >= so a range shrunk under a running
                            // table still wraps instead of running off
                            idx_d = (idx_q >= tlast[tbl_q]) ?
                                    tfirst[tbl_q] :
                                    idx_q + ADDR_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tbl_q   <= '0;
            slot_q  <= '0;
            err_q   <= 1'b0;
            ehold_q <= 1'b0;
            ent_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tbl_q   <= tbl_d;
            slot_q  <= slot_d;
            err_q   <= err_d;
            ehold_q <= ehold_d;
            if (state_q == FETCH) begin
                ent_q <= mem[idx_q];
            end
        end
    end

    // Entry store; a same-cycle fetch sees the pre-write word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_q <= '0;
        end else begin
            if (wr_en && ({1'b0, wr_addr} < DEPTH_C)) begin
                mem[wr_addr] <= wr_data;
            end
            rd_q <= ({1'b0, rd_addr} < DEPTH_C) ? mem[rd_addr] : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NT_ALL; i++) begin
                tfirst[i] <= '0;
                tlast[i]  <= '0;
            end
        end else if (cfg_wr && ({1'b0, cfg_tbl} < NT_C)) begin
            tfirst[cfg_tbl] <= cfg_first;
            tlast[cfg_tbl]  <= cfg_last;
        end
    end

    assign rd_data   = rd_q;
    assign frm_valid = (state_q == ISSUE);
    assign frm_pid   = ent_q[5:0];
    assign frm_type  = ent_q[7:6];
    assign frm_entry = ent_q;
    assign frm_idx   = idx_q;
    assign busy      = (state_q != IDLE);
    assign cur_tbl   = tbl_q;
    assign err_cfg   = err_q;

endmodule

// File: tb/tb_lin_schedule_sequencer.sv
// Bench for lin_schedule_sequencer: directed scenarios plus a
// randomized run checked against a schedule-walk model.
module tb_lin_schedule_sequencer;

    logic        clk = 0;
    logic        reset_n = 0;
    logic        wr_en = 0;
    logic [4:0]  wr_addr = 0;
    logic [31:0] wr_data = 0;
    logic [4:0]  rd_addr = 0;
    logic [31:0] rd_data;
    logic        cfg_wr = 0;
    logic [1:0]  cfg_tbl = 0;
    logic [4:0]  cfg_first = 0;
    logic [4:0]  cfg_last = 0;
    logic        run = 0;
    logic [1:0]  tbl_sel = 0;
    logic        tick = 0;
    logic        frm_valid;
    logic        frm_ready = 0;
    logic [5:0]  frm_pid;
    logic [1:0]  frm_type;
    logic [31:0] frm_entry;
    logic [4:0]  frm_idx;
    logic        busy;
    logic [1:0]  cur_tbl;
    logic        err_cfg;

    int vecs = 0;
    int errs = 0;

    logic [31:0] tb_mem [32];
    logic [4:0]  tf [4];
    logic [4:0]  tl [4];

    int hs_idx [$];
    int hs_tbl [$];
    int hs_ticks [$];
    logic [31:0] hs_ent [$];
    logic [7:0]  hs_pt [$];
    int hs_err;

    always #5 clk = ~clk;

    lin_schedule_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .cfg_wr(cfg_wr), .cfg_tbl(cfg_tbl),
        .cfg_first(cfg_first), .cfg_last(cfg_last),
        .run(run), .tbl_sel(tbl_sel), .tick(tick),
        .frm_valid(frm_valid), .frm_ready(frm_ready),
        .frm_pid(frm_pid), .frm_type(frm_type),
        .frm_entry(frm_entry), .frm_idx(frm_idx),
        .busy(busy), .cur_tbl(cur_tbl), .err_cfg(err_cfg)
    );

    function automatic int nxt(input int i, input int t);
        return (i == int'(tl[t])) ? int'(tf[t]) : i + 1;
    endfunction

    function automatic int slen(input int i);
        int l;
        l = int'(tb_mem[i][15:8]);
        return (l == 0) ? 1 : l;
    endfunction

    task automatic wr_entry(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 0;
        tb_mem[a] = d;
    endtask

    task automatic cfg_table(input logic [1:0] t, input logic [4:0] f,
                             input logic [4:0] l);
        cfg_wr = 1; cfg_tbl = t; cfg_first = f; cfg_last = l;
        @(negedge clk);
        cfg_wr = 0;
        tf[t] = f; tl[t] = l;
    endtask

    // Runs until n handshakes; records what was issued and how
    // many ticks each slot consumed (ticks never back to back in
    // random mode so the FETCH cycle never sees one).
    task automatic run_frames(input int n, input int tmode,
                              input bit rrdy, input int sw_idx,
                              input logic [1:0] sw_tbl,
                              output bit tmo);
        int cyc = 0;
        int cnt = 0;
        bit in_slot = 0;
        bit prev = 0;
        hs_idx.delete(); hs_tbl.delete(); hs_ticks.delete();
        hs_ent.delete(); hs_pt.delete(); hs_err = 0;
        run = 1;
        while (hs_idx.size() < n && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (err_cfg) hs_err++;
            frm_ready = rrdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tmode == 0) tick = !prev && ($urandom_range(0, 2) == 0);
            else tick = ((cyc % tmode) == 0);
            prev = tick;
            if (frm_valid && in_slot) begin
                hs_ticks.push_back(cnt);
                in_slot = 0;
            end
            if (tick && !frm_valid && in_slot) cnt++;
            if (frm_valid && frm_ready) begin
                hs_idx.push_back(int'(frm_idx));
                hs_tbl.push_back(int'(cur_tbl));
                hs_ent.push_back(frm_entry);
                hs_pt.push_back({frm_type, frm_pid});
                in_slot = 1;
                cnt = 0;
                if (int'(frm_idx) == sw_idx) tbl_sel = sw_tbl;
            end
        end
        @(negedge clk);
        tick = 0; frm_ready = 0;
        tmo = (hs_idx.size() < n);
    endtask

    task automatic drain();
        int c = 0;
        run = 0; frm_ready = 1;
        while (busy && c < 3000) begin
            tick = (c % 2 == 0);
            @(negedge clk);
            c++;
        end
        tick = 0; frm_ready = 0;
        @(negedge clk);
        vecs++;
        if (busy !== 1'b0) begin
            $display("FAIL drain busy=%b want 0", busy); errs++;
        end
    endtask

    task automatic test_reset();
        reset_n = 0;
        repeat (3) @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        vecs++;
        if ({frm_valid, busy, err_cfg} !== 3'b000) begin
            $display("FAIL reset_flags v/b/e=%b want 000",
                     {frm_valid, busy, err_cfg}); errs++;
        end
        vecs++;
        if (frm_entry !== 32'h0 || frm_idx !== 5'h0 || cur_tbl !== 2'h0) begin
            $display("FAIL reset_frm entry=%h idx=%0d tbl=%0d want 0",
                     frm_entry, frm_idx, cur_tbl); errs++;
        end
        rd_addr = 5'($urandom_range(0, 31));
        @(negedge clk);
        vecs++;
        if (rd_data !== 32'h0) begin
            $display("FAIL reset_rd rd=%h want 0", rd_data); errs++;
        end
    endtask

    task automatic test_basic();
        bit tmo;
        logic [5:0] pids [3];
        int exp_i;
        pids[0] = 6'h23; pids[1] = 6'h20; pids[2] = 6'h30;
        for (int i = 0; i < 3; i++)
            wr_entry(5'(i), {16'h0, 8'd2, 2'b00, pids[i]});
        for (int i = 0; i < 3; i++) begin
            rd_addr = 5'(i);
            @(negedge clk);
            vecs++;
            if (rd_data !== tb_mem[i]) begin
                $display("FAIL readback[%0d] got=%h want=%h",
                         i, rd_data, tb_mem[i]); errs++;
            end
        end
        cfg_table(0, 0, 2);
        tbl_sel = 0;
        run_frames(4, 4, 0, -1, 0, tmo);
        vecs++;
        if (tmo) begin
            $display("FAIL basic_timeout got=%0d want=4", hs_idx.size());
            errs++;
        end else begin
            exp_i = 0;
            for (int k = 0; k < 4; k++) begin
                vecs++;
                if (hs_pt[k][5:0] !== pids[exp_i]) begin
                    $display("FAIL basic_pid[%0d] got=%h want=%h",
                             k, hs_pt[k][5:0], pids[exp_i]); errs++;
                end
                exp_i = nxt(exp_i, 0);
            end
            for (int k = 0; k < 3; k++) begin
                vecs++;
                if (hs_ticks[k] != 2) begin
                    $display("FAIL basic_ticks[%0d] got=%0d want=2",
                             k, hs_ticks[k]); errs++;
                end
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        int c = 0;
        int cnt = 0;
        bit stable = 1;
        logic [5:0] pid0;
        tbl_sel = 0; run = 1; frm_ready = 0;
        while (!frm_valid && c < 20) begin @(negedge clk); c++; end
        pid0 = frm_pid;
        for (int i = 0; i < 10; i++) begin
            tick = (i % 2 == 0);
            @(negedge clk);
            if (frm_valid !== 1'b1 || frm_pid !== pid0) stable = 0;
        end
        tick = 0;
        vecs++;
        if (!stable || pid0 !== 6'h23) begin
            $display("FAIL bp_hold pid=%h stable=%0d want 23/1",
                     pid0, stable); errs++;
        end
        frm_ready = 1;
        @(negedge clk);
        frm_ready = 0;
        c = 0;
        while (!frm_valid && c < 50) begin
            tick = (c % 2 == 0);
            if (tick) cnt++;
            @(negedge clk);
            c++;
        end
        tick = 0;
        vecs++;
        if (cnt != slen(0) || frm_idx !== 5'd1) begin
            $display("FAIL bp_slot ticks=%0d idx=%0d want %0d/1",
                     cnt, frm_idx, slen(0)); errs++;
        end
        drain();
    endtask

    task automatic test_illegal_start();
        int ne = 0;
        bit seen = 0;
        cfg_table(2, 5, 3);
        tbl_sel = 2; run = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (err_cfg) ne++;
            if (busy || frm_valid) seen = 1;
        end
        run = 0;
        @(negedge clk);
        vecs++;
        if (ne != 1) begin
            $display("FAIL illegal_err pulses=%0d want=1", ne); errs++;
        end
        vecs++;
        if (seen) begin
            $display("FAIL illegal_busy active=1 want 0"); errs++;
        end
    endtask

    task automatic test_switch();
        bit tmo;
        int ei [5];
        int et [5];
        for (int i = 28; i < 32; i++) begin
            logic [31:0] d;
            d = $urandom;
            d[15:8] = 8'($urandom_range(1, 3));
            wr_entry(5'(i), d);
        end
        cfg_table(1, 28, 31);
        tbl_sel = 0;
        run_frames(5, 0, 1, 1, 1, tmo);
        ei = '{0, 1, 28, 29, 30};
        et = '{0, 0, 1, 1, 1};
        vecs++;
        if (tmo) begin
            $display("FAIL switch_timeout got=%0d want=5", hs_idx.size());
            errs++;
        end else begin
            for (int k = 0; k < 5; k++) begin
                vecs++;
                if (hs_idx[k] != ei[k] || hs_tbl[k] != et[k] ||
                    hs_ent[k] !== tb_mem[ei[k]]) begin
                    $display("FAIL switch[%0d] idx=%0d tbl=%0d ent=%h want %0d/%0d/%h",
                             k, hs_idx[k], hs_tbl[k], hs_ent[k],
                             ei[k], et[k], tb_mem[ei[k]]); errs++;
                end
            end
        end
        drain();
        tbl_sel = 1;
        run_frames(5, 0, 1, 28, 2, tmo);
        ei = '{28, 29, 30, 31, 28};
        vecs++;
        if (tmo) begin
            $display("FAIL badsw_timeout got=%0d want=5", hs_idx.size());
            errs++;
        end else begin
            for (int k = 0; k < 5; k++) begin
                vecs++;
                if (hs_idx[k] != ei[k] || hs_tbl[k] != 1) begin
                    $display("FAIL badsw[%0d] idx=%0d tbl=%0d want %0d/1",
                             k, hs_idx[k], hs_tbl[k], ei[k]); errs++;
                end
            end
            vecs++;
            if (hs_err != 4) begin
                $display("FAIL badsw_err pulses=%0d want=4", hs_err); errs++;
            end
        end
        drain();
    endtask

    task automatic test_collision();
        int c = 0;
        logic [31:0] od, nd;
        od = $urandom; od[15:8] = 8'd1;
        nd = $urandom; nd[15:8] = 8'd0;
        wr_entry(10, od);
        cfg_table(3, 10, 10);
        tbl_sel = 3; run = 1; frm_ready = 1;
        while (!frm_valid && c < 20) begin @(negedge clk); c++; end
        vecs++;
        if (frm_idx !== 5'd10 || frm_entry !== od) begin
            $display("FAIL coll_first idx=%0d ent=%h want 10/%h",
                     frm_idx, frm_entry, od); errs++;
        end
        @(negedge clk);
        tick = 1;
        @(negedge clk);
        tick = 0;
        wr_en = 1; wr_addr = 10; wr_data = nd;
        @(negedge clk);
        wr_en = 0;
        tb_mem[10] = nd;
        vecs++;
        if (frm_valid !== 1'b1 || frm_entry !== od) begin
            $display("FAIL coll_old v=%b ent=%h want 1/%h",
                     frm_valid, frm_entry, od); errs++;
        end
        @(negedge clk);
        tick = 1;
        @(negedge clk);
        tick = 0;
        @(negedge clk);
        vecs++;
        if (frm_valid !== 1'b1 || frm_idx !== 5'd10 ||
            frm_entry !== nd) begin
            $display("FAIL coll_new v=%b idx=%0d ent=%h want 1/10/%h",
                     frm_valid, frm_idx, frm_entry, nd); errs++;
        end
        drain();
    endtask

    task automatic test_random();
        bit tmo;
        int f, l, ei;
        for (int i = 0; i < 32; i++) begin
            logic [31:0] d;
            d = $urandom;
            d[15:8] = 8'($urandom_range(0, 3));
            wr_entry(5'(i), d);
        end
        for (int k = 0; k < 4; k++) begin
            int a;
            a = $urandom_range(0, 31);
            rd_addr = 5'(a);
            @(negedge clk);
            vecs++;
            if (rd_data !== tb_mem[a]) begin
                $display("FAIL rnd_rd[%0d] got=%h want=%h",
                         a, rd_data, tb_mem[a]); errs++;
            end
        end
        f = $urandom_range(0, 24);
        l = f + $urandom_range(0, 7);
        cfg_table(0, 5'(f), 5'(l));
        tbl_sel = 0;
        run_frames(25, 0, 1, -1, 0, tmo);
        vecs++;
        if (tmo) begin
            $display("FAIL rnd_timeout got=%0d want=25", hs_idx.size());
            errs++;
        end else begin
            ei = f;
            for (int k = 0; k < 25; k++) begin
                vecs++;
                if (hs_idx[k] != ei || hs_ent[k] !== tb_mem[ei] ||
                    hs_pt[k] !== tb_mem[ei][7:0]) begin
                    $display("FAIL rnd[%0d] idx=%0d ent=%h pt=%h want %0d/%h",
                             k, hs_idx[k], hs_ent[k], hs_pt[k],
                             ei, tb_mem[ei]); errs++;
                end
                if (k < 24) begin
                    vecs++;
                    if (hs_ticks[k] != slen(ei)) begin
                        $display("FAIL rnd_ticks[%0d] got=%0d want=%0d",
                                 k, hs_ticks[k], slen(ei)); errs++;
                    end
                end
                ei = nxt(ei, 0);
            end
        end
        drain();
    endtask

    task automatic test_reset_midslot();
        int c = 0;
        tbl_sel = 1; run = 1; frm_ready = 1;
        while (!frm_valid && c < 20) begin @(negedge clk); c++; end
        @(negedge clk);
        frm_ready = 0;
        rd_addr = 28;
        @(negedge clk);
        vecs++;
        if (busy !== 1'b1 || cur_tbl !== 2'd1) begin
            $display("FAIL mid_pre busy=%b tbl=%0d want 1/1",
                     busy, cur_tbl); errs++;
        end
        #2 reset_n = 0;
        #1;
        vecs++;
        if ({frm_valid, busy, err_cfg} !== 3'b000 || frm_entry !== 32'h0 ||
            frm_pid !== 6'h0 || frm_type !== 2'h0 || frm_idx !== 5'h0 ||
            cur_tbl !== 2'h0 || rd_data !== 32'h0) begin
            $display("FAIL mid_async vbe=%b ent=%h idx=%0d tbl=%0d rd=%h want 0",
                     {frm_valid, busy, err_cfg}, frm_entry, frm_idx,
                     cur_tbl, rd_data); errs++;
        end
        run = 0;
        for (int i = 0; i < 32; i++) tb_mem[i] = '0;
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        @(negedge clk);
        vecs++;
        if (busy !== 1'b0 || rd_data !== tb_mem[28]) begin
            $display("FAIL mid_after busy=%b rd=%h want 0/%h",
                     busy, rd_data, tb_mem[28]); errs++;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) tb_mem[i] = '0;
        for (int i = 0; i < 4; i++) begin tf[i] = 0; tl[i] = 0; end
        test_reset();
        test_basic();
        test_backpressure();
        test_illegal_start();
        test_switch();
        test_collision();
        test_random();
        test_reset_midslot();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
